// File: rtl/dvp_capture.sv
`default_nettype none
// ============================================================================
// Module      : dvp_capture
// Description : DVP sensor capture. Assembles RGB565 byte pairs into RGB888
//               pixels with coordinates and locks onto stable frame geometry.
// Revision    : 1.0 - initial release
// ============================================================================
module dvp_capture #(
    parameter int H_ACTIVE    = 1280,
    parameter int V_ACTIVE    = 720,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        dvp_pixel_clk,
    input  logic        rst_n,
    input  logic        dvp_vsync,
    input  logic        dvp_de,
    input  logic [7:0]  dvp_data,
    output logic        pix_valid,
    output logic [23:0] pix_rgb,
    output logic [11:0] pix_x,
    output logic [10:0] pix_y,
    output logic        pix_sof,
    output logic        pix_eol,
    output logic        frame_locked,
    output logic        line_err,
    output logic        frame_err
);

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    localparam logic [11:0] C_H_ACTIVE = 12'(H_ACTIVE);
    localparam logic [11:0] C_H_LAST   = 12'(H_ACTIVE - 1);
    localparam logic [10:0] C_V_ACTIVE = 11'(V_ACTIVE);
    localparam logic [3:0]  C_LOCK     = 4'(LOCK_FRAMES);

    // input stage and edge history
    logic        vsync_q, vsync_prev_q;
    logic        de_q, de_prev_q;
    logic [7:0]  data_q;

    // line / frame tracking
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [11:0] x_q, x_d;
    logic        line_over_q, line_over_d;
    logic        skip_q, skip_d;
    logic [10:0] y_q, y_d;
    logic        frame_bad_q, frame_bad_d;

    // lock FSM
    logic [1:0]  state_q, state_d;
    logic [3:0]  good_cnt_q, good_cnt_d;

    // output registers
    logic        pix_valid_q, pix_valid_d;
    logic [23:0] pix_rgb_q, pix_rgb_d;
    logic [11:0] pix_x_q, pix_x_d;
    logic [10:0] pix_y_q, pix_y_d;
    logic        pix_sof_q, pix_sof_d;
    logic        pix_eol_q, pix_eol_d;
    logic        line_err_q, line_err_d;
    logic        frame_err_q, frame_err_d;
    logic        frame_locked_q, frame_locked_d;

    logic        vsync_rise;
    logic        de_fall;
    logic        byte_live;
    logic        word_done;
    logic        line_end;
    logic        line_bad;
    logic        x_in_range;
    logic        y_in_range;
    logic        emit;
    logic        frame_good;
    logic [15:0] word;
    logic [23:0] rgb888;

    always_ff @(posedge dvp_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b0;
            vsync_prev_q <= 1'b0;
            de_q         <= 1'b0;
            de_prev_q    <= 1'b0;
            data_q       <= 8'd0;
        end else begin
            vsync_q      <= dvp_vsync;
            vsync_prev_q <= vsync_q;
            de_q         <= dvp_de;
            de_prev_q    <= de_q;
            data_q       <= dvp_data;
        end
    end

    always_comb begin
        vsync_rise = vsync_q & ~vsync_prev_q;
        de_fall    = ~de_q & de_prev_q;
        // A line cut by vsync is ignored until de drops
        byte_live  = de_q & ~skip_q & ~vsync_rise;
        word_done  = byte_live & phase_q;
        line_end   = de_fall & ~skip_q & ~vsync_rise;
        x_in_range = (x_q < C_H_ACTIVE);
        y_in_range = (y_q < C_V_ACTIVE);
        line_bad   = (x_q != C_H_ACTIVE) | line_over_q | phase_q;
        emit       = word_done & (state_q != S_SEARCH) & x_in_range & y_in_range;
        frame_good = (y_q == C_V_ACTIVE) & ~frame_bad_q;
        word       = {hi_q, data_q};
        rgb888     = {word[15:11], word[15:13],
                      word[10:5],  word[10:9],
                      word[4:0],   word[4:2]};
    end

    always_comb begin
        phase_d     = byte_live ? ~phase_q : 1'b0;
        hi_d        = (byte_live & ~phase_q) ? data_q : hi_q;
        skip_d      = skip_q;
        x_d         = x_q;
        line_over_d = line_over_q;
        y_d         = y_q;
        frame_bad_d = frame_bad_q;

        if (vsync_rise) begin
            skip_d = de_q;
        end else if (!de_q) begin
            skip_d = 1'b0;
        end

        if (vsync_rise) begin
            x_d         = 12'd0;
            line_over_d = 1'b0;
            y_d         = 11'd0;
            frame_bad_d = 1'b0;
        end else begin
            if (word_done) begin
                if (x_in_range) begin
                    x_d = x_q + 12'd1;
                end else begin
                    line_over_d = 1'b1;
                end
                if (!x_in_range || !y_in_range) begin
                    frame_bad_d = 1'b1;
                end
            end
            if (de_fall) begin
                x_d         = 12'd0;
                line_over_d = 1'b0;
            end
            if (line_end) begin
                if (y_in_range) begin
                    y_d = y_q + 11'd1;
                end
                if (line_bad || !y_in_range) begin
                    frame_bad_d = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        good_cnt_d  = good_cnt_q;
        frame_err_d = 1'b0;
        if (vsync_rise) begin
            case (state_q)
                S_SEARCH: begin
                    state_d    = S_CHECK;
                    good_cnt_d = 4'd0;
                end
                S_CHECK: begin
                    if (frame_good) begin
                        good_cnt_d = good_cnt_q + 4'd1;
                        if (good_cnt_q + 4'd1 == C_LOCK) begin
                            state_d = S_LOCKED;
                        end
                    end else begin
                        good_cnt_d = 4'd0;
                    end
                end
                S_LOCKED: begin
                    if (!frame_good) begin
                        state_d     = S_CHECK;
                        good_cnt_d  = 4'd0;
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d    = S_SEARCH;
                    good_cnt_d = 4'd0;
                end
            endcase
        end
    end

    always_comb begin
        pix_valid_d    = emit;
        pix_rgb_d      = emit ? rgb888 : pix_rgb_q;
        pix_x_d        = emit ? x_q : pix_x_q;
        pix_y_d        = emit ? y_q : pix_y_q;
        pix_sof_d      = emit & (x_q == 12'd0) & (y_q == 11'd0);
        pix_eol_d      = emit & (x_q == C_H_LAST);
        line_err_d     = line_end & line_bad & (state_q != S_SEARCH);
        frame_locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge dvp_pixel_clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q        <= 1'b0;
            hi_q           <= 8'd0;
            x_q            <= 12'd0;
            line_over_q    <= 1'b0;
            skip_q         <= 1'b0;
            y_q            <= 11'd0;
            frame_bad_q    <= 1'b0;
            state_q        <= S_SEARCH;
            good_cnt_q     <= 4'd0;
            pix_valid_q    <= 1'b0;
            pix_rgb_q      <= 24'd0;
            pix_x_q        <= 12'd0;
            pix_y_q        <= 11'd0;
            pix_sof_q      <= 1'b0;
            pix_eol_q      <= 1'b0;
            line_err_q     <= 1'b0;
            frame_err_q    <= 1'b0;
            frame_locked_q <= 1'b0;
        end else begin
            phase_q        <= phase_d;
            hi_q           <= hi_d;
            x_q            <= x_d;
            line_over_q    <= line_over_d;
            skip_q         <= skip_d;
            y_q            <= y_d;
            frame_bad_q    <= frame_bad_d;
            state_q        <= state_d;
            good_cnt_q     <= good_cnt_d;
            pix_valid_q    <= pix_valid_d;
            pix_rgb_q      <= pix_rgb_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            pix_sof_q      <= pix_sof_d;
            pix_eol_q      <= pix_eol_d;
            line_err_q     <= line_err_d;
            frame_err_q    <= frame_err_d;
            frame_locked_q <= frame_locked_d;
        end
    end

    assign pix_valid    = pix_valid_q;
    assign pix_rgb      = pix_rgb_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign pix_sof      = pix_sof_q;
    assign pix_eol      = pix_eol_q;
    assign line_err     = line_err_q;
    assign frame_err    = frame_err_q;
    assign frame_locked = frame_locked_q;

endmodule
`default_nettype wire

// File: tb/tb_dvp_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_dvp_capture
// Description : Directed bench for dvp_capture with a frame-level reference
//               model and a per-cycle output comparator.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvp_capture;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int LOCK = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b0;
    logic        de = 1'b0;
    logic [7:0]  data = 8'd0;
    logic        pix_valid, pix_sof, pix_eol, frame_locked, line_err, frame_err;
    logic [23:0] pix_rgb;
    logic [11:0] pix_x;
    logic [10:0] pix_y;

    dvp_capture #(.H_ACTIVE(H), .V_ACTIVE(V), .LOCK_FRAMES(LOCK)) dut (
        .dvp_pixel_clk (clk),
        .rst_n         (rst_n),
        .dvp_vsync     (vsync),
        .dvp_de        (de),
        .dvp_data      (data),
        .pix_valid     (pix_valid),
        .pix_rgb       (pix_rgb),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_sof       (pix_sof),
        .pix_eol       (pix_eol),
        .frame_locked  (frame_locked),
        .line_err      (line_err),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [23:0] rgb;
        logic [11:0] x;
        logic [10:0] y;
        logic        sof;
        logic        eol;
    } pix_t;

    // expectations keyed by the cycle in which the output must be seen
    pix_t exp_pix[int];
    bit   exp_lerr[int];
    bit   exp_ferr[int];
    bit   exp_lock_at[int];

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, expv);
        end
    endtask

    function automatic logic [23:0] exp565(input logic [15:0] w);
        int r5, g6, b5;
        r5 = int'(w[15:11]);
        g6 = int'(w[10:5]);
        b5 = int'(w[4:0]);
        return {8'(r5 * 8 + r5 / 4), 8'(g6 * 4 + g6 / 16), 8'(b5 * 8 + b5 / 4)};
    endfunction

    // comparator
    logic [23:0] cur_rgb = '0;
    logic [11:0] cur_x = '0;
    logic [10:0] cur_y = '0;
    logic        cur_lock = 1'b0;
    logic        ev, es, ee, el, ef;
    logic        prev_lock = 1'b0;
    int n_valid = 0, n_lerr = 0, n_ferr = 0, n_sof = 0, n_eol = 0;
    int lock_rise_cyc = -1;
    logic [23:0] obs_rgb[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            cur_rgb  = '0;
            cur_x    = '0;
            cur_y    = '0;
            cur_lock = 1'b0;
            check("reset_outputs", {11'd0, pix_valid, pix_sof, pix_eol, line_err, frame_err,
                                    frame_locked, pix_rgb, pix_x, pix_y}, 64'd0);
        end else begin
            if (exp_lock_at.exists(cyc)) cur_lock = exp_lock_at[cyc];
            ev = exp_pix.exists(cyc);
            es = 1'b0;
            ee = 1'b0;
            if (ev) begin
                cur_rgb = exp_pix[cyc].rgb;
                cur_x   = exp_pix[cyc].x;
                cur_y   = exp_pix[cyc].y;
                es      = exp_pix[cyc].sof;
                ee      = exp_pix[cyc].eol;
            end
            check("pixel", {pix_valid, pix_sof, pix_eol, pix_rgb, pix_x, pix_y},
                           {ev, es, ee, cur_rgb, cur_x, cur_y});
            el = exp_lerr.exists(cyc);
            ef = exp_ferr.exists(cyc);
            check("control", {line_err, frame_err, frame_locked}, {el, ef, cur_lock});
            if (pix_valid) begin
                n_valid++;
                obs_rgb.push_back(pix_rgb);
                if (pix_sof) n_sof++;
                if (pix_eol) n_eol++;
            end
            if (line_err) n_lerr++;
            if (frame_err) n_ferr++;
            if (frame_locked && !prev_lock) lock_rise_cyc = cyc;
        end
        prev_lock = frame_locked;
    end

    // frame-level reference model state: 0 search, 1 check, 2 locked
    int m_state = 0, m_cnt = 0, m_lines = 0, m_nbytes = 0;
    bit m_bad = 1'b0;
    logic [7:0] m_hi = 8'd0;
    int vsync_cyc = 0;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive_byte(input logic [7:0] b);
        int   k;
        pix_t p;
        de   = 1'b1;
        data = b;
        if (m_nbytes % 2 == 0) begin
            m_hi = b;
        end else begin
            k = m_nbytes / 2;
            if (m_state != 0 && m_lines < V && k < H) begin
                p.rgb = exp565({m_hi, b});
                p.x   = 12'(k);
                p.y   = 11'(m_lines);
                p.sof = (k == 0 && m_lines == 0);
                p.eol = (k == H - 1);
                exp_pix[cyc + 2] = p;
            end
        end
        m_nbytes++;
        step(1);
    endtask

    task automatic end_line();
        de   = 1'b0;
        data = 8'd0;
        if (m_state != 0 && m_nbytes != 2 * H) exp_lerr[cyc + 2] = 1'b1;
        if (m_nbytes != 2 * H || m_lines >= V) m_bad = 1'b1;
        if (m_lines < V) m_lines++;
        m_nbytes = 0;
        step(2);
    endtask

    logic [7:0] lead [4] = '{8'hF8, 8'h1F, 8'h07, 8'hE0};

    task automatic drive_line(input int nbytes, input int seed, input bit use_lead);
        for (int i = 0; i < nbytes; i++) begin
            if (use_lead && i < 4) drive_byte(lead[i]);
            else drive_byte(8'(seed * 29 + i * 7 + 5));
        end
        end_line();
    endtask

    task automatic drive_frame(input int bad_line, input int bad_n, input int seed, input bit use_lead);
        for (int l = 0; l < V; l++) begin
            drive_line((l == bad_line) ? bad_n : 2 * H, seed + l * 13, use_lead && l == 0);
        end
    endtask

    task automatic do_vsync();
        bit good;
        vsync = 1'b1;
        good  = (m_lines == V) && !m_bad;
        case (m_state)
            0: begin
                m_state = 1;
                m_cnt   = 0;
            end
            1: begin
                if (good) begin
                    m_cnt++;
                    if (m_cnt == LOCK) begin
                        m_state = 2;
                        exp_lock_at[cyc + 2] = 1'b1;
                    end
                end else begin
                    m_cnt = 0;
                end
            end
            default: begin
                if (!good) begin
                    m_state = 1;
                    m_cnt   = 0;
                    exp_ferr[cyc + 2]    = 1'b1;
                    exp_lock_at[cyc + 2] = 1'b0;
                end
            end
        endcase
        m_lines   = 0;
        m_bad     = 1'b0;
        m_nbytes  = 0;
        vsync_cyc = cyc;
        step(3);
        vsync = 1'b0;
        step(2);
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0;
        de    = 1'b0;
        data  = 8'd0;
        vsync = 1'b0;
        exp_pix.delete();
        exp_lerr.delete();
        exp_ferr.delete();
        exp_lock_at.delete();
        m_state  = 0;
        m_cnt    = 0;
        m_lines  = 0;
        m_nbytes = 0;
        m_bad    = 1'b0;
        step(n);
        rst_n = 1'b1;
        step(2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    int snap_valid, snap_lerr;

    initial begin
        // reset held with the sensor inputs wiggling
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            vsync = i[0];
            de    = i[1];
            data  = 8'(i * 37 + 1);
        end
        vsync = 1'b0;
        de    = 1'b0;
        data  = 8'd0;
        step(1);
        rst_n = 1'b1;
        step(2);

        drive_line(2 * H, 3, 1'b0);
        drive_line(2 * H, 4, 1'b0);
        check("search_no_valid", n_valid, 0);

        do_vsync();
        drive_frame(-1, 0, 10, 1'b1);
        do_vsync();
        check("rgb_f81f", obs_rgb[0], 24'hFF00FF);
        check("rgb_07e0", obs_rgb[1], 24'h00FF00);
        check("frame_pixels", n_valid, 32);
        check("sof_count", n_sof, 1);
        check("eol_count", n_eol, 4);
        check("not_locked_yet", frame_locked, 0);

        drive_frame(-1, 0, 20, 1'b0);
        do_vsync();
        check("lock_rise_cycle", lock_rise_cyc, vsync_cyc + 2);
        check("locked", frame_locked, 1);

        drive_frame(-1, 0, 30, 1'b0);
        do_vsync();
        check("stay_locked", frame_locked, 1);

        snap_lerr = n_lerr;
        drive_frame(1, 14, 40, 1'b0);
        check("short_line_err", n_lerr - snap_lerr, 1);
        do_vsync();
        check("short_frame_err", n_ferr, 1);
        check("lock_drop", frame_locked, 0);

        snap_lerr = n_lerr;
        drive_frame(2, 17, 50, 1'b0);
        check("odd_line_err", n_lerr - snap_lerr, 1);
        do_vsync();

        snap_lerr  = n_lerr;
        snap_valid = n_valid;
        drive_frame(0, 18, 60, 1'b0);
        check("long_line_err", n_lerr - snap_lerr, 1);
        check("long_line_pixels", n_valid - snap_valid, 32);
        do_vsync();
        check("long_no_lock", frame_locked, 0);

        drive_frame(-1, 0, 70, 1'b0);
        do_vsync();
        drive_frame(-1, 0, 80, 1'b0);
        do_vsync();
        check("relocked", frame_locked, 1);

        // reset in the middle of line 2
        drive_line(2 * H, 90, 1'b0);
        drive_line(2 * H, 91, 1'b0);
        for (int i = 0; i < 5; i++) drive_byte(8'(i * 11 + 3));
        apply_reset(3);
        check("reset_unlock", frame_locked, 0);
        snap_valid = n_valid;
        for (int i = 0; i < 3; i++) drive_byte(8'(i * 5 + 1));
        end_line();
        drive_line(2 * H, 92, 1'b0);
        check("post_reset_search", n_valid - snap_valid, 0);

        do_vsync();
        drive_frame(-1, 0, 100, 1'b0);
        do_vsync();
        check("relock_pending", frame_locked, 0);
        drive_frame(-1, 0, 110, 1'b0);
        do_vsync();
        check("relock_after_reset", frame_locked, 1);

        step(4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dvp_capture.md
DVP_CAPTURE -- requirements
Module: dvp_capture

Interface
REQ-001 Parameter H_ACTIVE, default 1280, active pixels per line.
REQ-002 Parameter V_ACTIVE, default 720, active lines per frame.
REQ-003 Parameter LOCK_FRAMES, default 2, consecutive good frames required to assert frame_locked; legal range 1..15.
REQ-004 dvp_pixel_clk  in  1  sole clock; every flop is clocked on the rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 dvp_vsync  in  1  sensor frame sync; a rising edge marks frame start.
REQ-007 dvp_de  in  1  sensor data enable; high during active bytes.
REQ-008 dvp_data  in  8  sensor byte; RGB565, high byte first.
REQ-009 pix_valid  out  1  one-cycle strobe, pixel outputs valid.
REQ-010 pix_rgb  out  24  RGB888 pixel {R,G,B}.
REQ-011 pix_x  out  12  pixel column, 0..H_ACTIVE-1.
REQ-012 pix_y  out  11  pixel row, 0..V_ACTIVE-1.
REQ-013 pix_sof  out  1  high with pix_valid for pixel (0,0).
REQ-014 pix_eol  out  1  high with pix_valid for pixel x=H_ACTIVE-1.
REQ-015 frame_locked  out  1  level, stream geometry is stable.
REQ-016 line_err  out  1  one-cycle pulse, malformed line.
REQ-017 frame_err  out  1  one-cycle pulse, a bad frame while LOCKED.

Function
REQ-018 dvp_vsync, dvp_de and dvp_data shall be registered once (input stage) before any use; edges are detected on the registered copies.
REQ-019 A byte-phase flag shall toggle on each registered byte with de high and clear whenever registered de is low.
REQ-020 Phase 0 shall store the byte as the high byte; phase 1 shall complete the 16-bit word {hi,lo}.
REQ-021 Expansion: R={w[15:11],w[15:13]}, G={w[10:5],w[10:9]}, B={w[4:0],w[4:2]}.
REQ-022 pix_valid shall assert at the clock edge following the edge that registers the phase-1 byte into the input stage; latency is fixed.
REQ-023 The FSM shall have the states SEARCH, CHECK and LOCKED.
REQ-024 No pix_valid, pix_sof, pix_eol or line_err shall be issued in SEARCH.
REQ-025 SEARCH -> CHECK on the first vsync rising edge, with good_cnt=0.
REQ-026 On each vsync rising edge, x, y and phase shall clear and the frame just ended shall be judged.
REQ-027 A frame is good iff exactly V_ACTIVE lines were seen, each with exactly H_ACTIVE pixels and no odd byte count.
REQ-028 CHECK on a good frame: good_cnt++, and -> LOCKED when good_cnt reaches LOCK_FRAMES.
REQ-029 CHECK on a bad frame: good_cnt=0 and stay in CHECK.
REQ-030 LOCKED on a bad frame: -> CHECK with good_cnt=0 and a frame_err pulse in the same cycle.
REQ-031 frame_locked shall be high iff the state is LOCKED; it deasserts the cycle the FSM leaves LOCKED.
REQ-032 pix_x shall increment per emitted pixel.
REQ-033 On a registered de falling edge: y++ (saturating at V_ACTIVE) and x clears.
REQ-034 line_err shall pulse on a de falling edge when the pixel count is not H_ACTIVE or the phase is 1; that line marks the frame bad.
REQ-035 Pixels beyond H_ACTIVE in a line, and all pixels of lines beyond V_ACTIVE, shall be suppressed (no pix_valid) and mark the frame bad.
REQ-036 A vsync rising edge while de is high shall abort the line without a line_err pulse; the frame is judged bad by line count.
REQ-037 pix_rgb, pix_x and pix_y shall hold their last values between strobes.

Reset
REQ-038 While rst_n is low, all outputs shall be 0, the state SEARCH, good_cnt, x, y and phase 0, and the input stage 0.
REQ-039 Reset asserted mid-frame shall discard the partial pixel and frame; after release the block waits in SEARCH for a fresh vsync rising edge.

Verification
REQ-040 Reset: hold rst_n low with toggling inputs -> all outputs 0; no pix_valid before the first vsync rising edge.
REQ-041 Pixel path: bytes 0xF8,0x1F with de high -> pix_rgb=0xFF00FF, pix_valid exactly 1 cycle; bytes 0x07,0xE0 -> 0x00FF00.
REQ-042 Lock: with H_ACTIVE=8, V_ACTIVE=4, LOCK_FRAMES=2, drive 3 vsync edges with well-formed frames -> frame_locked rises the cycle after the 3rd vsync rising edge is registered; pix_sof is seen on (0,0) and pix_eol on x=7.
REQ-043 Short line: 7 pixels in one line while LOCKED -> one line_err pulse at the de fall, frame_err at the next vsync rising edge, frame_locked drops.
REQ-044 Odd bytes / long line: 17 bytes in one line -> line_err; a 9-pixel line -> the 9th pixel is suppressed and line_err fires.
REQ-045 Mid-frame reset: assert rst_n during line 2 -> outputs cleared; relock requires LOCK_FRAMES good frames after a new vsync rising edge.
